// File: rtl/adc_spi_responder.sv
// adc_spi_responder: ADC-side SPI responder for hardware-in-the-loop tests.
// It returns FIFO samples on NUM_SDI lanes during conversion frames and
// forwards 24-bit register-write frames on an AXI-Stream master.
// Optional feature macro: ADC_RESPONDER_RAMP_EN (ramp pattern on underflow).
//
// Handshakes (both AXI-Stream ports): a beat transfers on a rising aclk edge
// where tvalid & tready are both high. Once asserted, m_axis_tvalid and
// m_axis_tdata hold until that transfer. s_axis_tready does not depend on
// s_axis_tvalid.
module adc_spi_responder #(
  parameter int NUM_SDI    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               spi_csn,
  input  logic               spi_sdi,
  output logic [NUM_SDI-1:0] spi_sdo,
  input  logic               spi_resetn,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [31:0]        status
);

  localparam int         CNV        = 32 / NUM_SDI;
  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [4:0] CNT_CHUNKS = 5'(CNV);
  localparam logic [4:0] CNT_CONV   = 5'(CNV + 1);
  localparam logic [4:0] CNT_REG    = 5'd25;

  // The initiator's device reset behaves exactly like areset.
  logic rst;
  assign rst = areset | ~spi_resetn;

  logic [4:0]  cnt;
  logic        armed;   // set once csn is seen high after reset
  logic [23:0] sreg;
  logic [31:0] cur_sample;
  logic [7:0]  uf_cnt;
  logic [7:0]  fe_cnt;
  logic        sticky;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  logic frame_end;
  logic conv_end;
  logic reg_end;
  logic err_end;
  logic underflow;
  logic m_hs;
  logic reg_accept;

  assign level         = wr_ptr - rd_ptr;
  assign fifo_empty    = (level == '0);
  assign fifo_full     = (level == (AW+1)'(FIFO_DEPTH));
  assign s_axis_tready = ~fifo_full;
  assign push          = s_axis_tvalid & s_axis_tready;

  // A frame ends on the first high csn sample after at least one counted low edge.
  assign frame_end  = spi_csn & (cnt != 5'd0);
  assign conv_end   = frame_end & (cnt == CNT_CONV);
  assign reg_end    = frame_end & (cnt == CNT_REG);
  assign err_end    = frame_end & ~conv_end & ~reg_end;
  assign pop        = conv_end & ~fifo_empty;
  assign underflow  = conv_end & fifo_empty;
  assign m_hs       = m_axis_tvalid & m_axis_tready;
  // A register word is taken if the output slot is empty or is draining this edge.
  assign reg_accept = reg_end & (~m_axis_tvalid | m_axis_tready);

  // Frame edge counter and register-write shift register.
  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt   <= 5'd0;
      armed <= 1'b0;
      sreg  <= 24'd0;
    end else if (spi_csn) begin
      armed <= 1'b1;
      cnt   <= 5'd0;
    end else if (armed) begin
      if (cnt != 5'd31) cnt <= cnt + 5'd1;
      if (cnt < 5'd24) sreg <= {sreg[22:0], spi_sdi};
    end
  end

  // Sample FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge aclk) begin
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
  end

  // Sample FIFO pointers.
  always_ff @(posedge aclk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef ADC_RESPONDER_RAMP_EN
  logic [31:0] ramp;

  // Ramp pattern source, advanced once per underflow.
  always_ff @(posedge aclk) begin
    if (rst)            ramp <= 32'd0;
    else if (underflow) ramp <= ramp + 32'd1;
  end

  // Current sample reload at conversion frame end; ramp value on underflow.
  always_ff @(posedge aclk) begin
    if (rst)            cur_sample <= 32'd0;
    else if (pop)       cur_sample <= mem[rd_ptr[AW-1:0]];
    else if (underflow) cur_sample <= ramp;
  end
`else
  // Current sample reload at conversion frame end; zero on underflow.
  always_ff @(posedge aclk) begin
    if (rst)            cur_sample <= 32'd0;
    else if (pop)       cur_sample <= mem[rd_ptr[AW-1:0]];
    else if (underflow) cur_sample <= 32'd0;
  end
`endif

  // Saturating underflow and frame-error counters plus the overflow sticky bit.
  always_ff @(posedge aclk) begin
    if (rst) begin
      uf_cnt <= 8'd0;
      fe_cnt <= 8'd0;
      sticky <= 1'b0;
    end else begin
      if (underflow && uf_cnt != 8'd255) uf_cnt <= uf_cnt + 8'd1;
      if (err_end && fe_cnt != 8'd255)   fe_cnt <= fe_cnt + 8'd1;
      if (reg_end && !reg_accept)        sticky <= 1'b1;
    end
  end

  // Register-word output slot.
  always_ff @(posedge aclk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 32'd0;
    end else if (reg_accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {8'd0, sreg};
    end else if (m_hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  logic [31:0] sdo_word;

  // Present the chunk selected by cnt, MSB chunk first; idle lanes read zero.
  always_comb begin
    sdo_word = cur_sample << (NUM_SDI * cnt);
    spi_sdo  = '0;
    if (cnt < CNT_CHUNKS) spi_sdo = sdo_word[31 -: NUM_SDI];
  end

  assign status = {9'd0, 5'(level), (cnt != 5'd0), sticky, fe_cnt, uf_cnt};

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: a frame-level behavioural model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_adc_spi_responder;

  localparam int NUM_SDI = 4;
  localparam int DEPTH   = 16;
  localparam int CHUNKS  = 32 / NUM_SDI;

  // Clock and reset block.
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic               areset;
  logic               spi_csn;
  logic               spi_sdi;
  logic [NUM_SDI-1:0] spi_sdo;
  logic               spi_resetn;
  logic [31:0]        s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [31:0]        m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [31:0]        status;

  adc_spi_responder #(.NUM_SDI(NUM_SDI), .FIFO_DEPTH(DEPTH)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .spi_csn       (spi_csn),
    .spi_sdi       (spi_sdi),
    .spi_sdo       (spi_sdo),
    .spi_resetn    (spi_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .status        (status)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: sample FIFO as a queue, frames classified by low-edge count.
  logic [31:0] exp_q[$];
  logic [31:0] m_cur;
  int          m_run;
  bit          m_armed;
  logic [23:0] m_sreg;
  int          m_uf;
  int          m_fe;
  bit          m_sticky;
  bit          m_tvalid;
  logic [31:0] m_tdata;
  logic [31:0] m_ramp;
  bit          model_ok = 0;
  bit          do_push;
  logic [31:0] push_val;
  bit          hs;
  bit          took;

  always @(posedge aclk) begin
    if (areset || !spi_resetn) begin
      exp_q.delete();
      m_cur = 0; m_run = 0; m_armed = 0; m_sreg = 0;
      m_uf = 0; m_fe = 0; m_sticky = 0;
      m_tvalid = 0; m_tdata = 0; m_ramp = 0;
      model_ok = 1;
    end else begin
      do_push  = s_axis_tvalid && (exp_q.size() < DEPTH);
      push_val = s_axis_tdata;
      hs       = m_tvalid && m_axis_tready;
      took     = 0;
      if (!spi_csn) begin
        if (m_armed) begin
          if (m_run < 24) m_sreg = {m_sreg[22:0], spi_sdi};
          m_run++;
        end
      end else begin
        m_armed = 1;
        if (m_run == CHUNKS + 1) begin
          if (exp_q.size() > 0) m_cur = exp_q.pop_front();
          else begin
            if (m_uf < 255) m_uf++;
`ifdef ADC_RESPONDER_RAMP_EN
            m_cur  = m_ramp;
            m_ramp = m_ramp + 1;
`else
            m_cur = 0;
`endif
          end
        end else if (m_run == 25) begin
          if (!m_tvalid || m_axis_tready) begin
            m_tdata = {8'd0, m_sreg};
            took    = 1;
          end else m_sticky = 1;
        end else if (m_run != 0) begin
          if (m_fe < 255) m_fe++;
        end
        m_run = 0;
      end
      if (took) m_tvalid = 1;
      else if (hs) m_tvalid = 0;
      if (do_push) exp_q.push_back(push_val);
    end
  end

  // Compare process: every cycle once the model has seen a reset edge.
  logic [NUM_SDI-1:0] e_sdo;
  logic [31:0]        e_status;
  always @(negedge aclk) begin
    if (model_ok) begin
      e_sdo = '0;
      if (m_run < CHUNKS) e_sdo = NUM_SDI'(m_cur >> (32 - NUM_SDI * (m_run + 1)));
      e_status = {9'd0, 5'(exp_q.size()), (m_run != 0), m_sticky, 8'(m_fe), 8'(m_uf)};
      check("cyc_sdo",    32'(spi_sdo), 32'(e_sdo));
      check("cyc_tready", 32'(s_axis_tready), 32'(exp_q.size() < DEPTH));
      check("cyc_tvalid", 32'(m_axis_tvalid), 32'(m_tvalid));
      check("cyc_tdata",  m_axis_tdata, m_tdata);
      check("cyc_status", status, e_status);
    end
  end

  // Driver tasks.
  logic [NUM_SDI-1:0] got [CHUNKS];
  logic [31:0]        got_word;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = v;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic frame(input int n, input logic [23:0] w, input bit rdy_end);
    for (int i = 0; i < n; i++) begin
      spi_csn = 1'b0;
      spi_sdi = (i < 24) ? w[23-i] : 1'b0;
      if (i < CHUNKS) got[i] = spi_sdo;
      tick();
    end
    spi_csn = 1'b1;
    spi_sdi = 1'b0;
    if (rdy_end) m_axis_tready = 1'b1;
    tick();
    got_word = 0;
    for (int i = 0; i < CHUNKS; i++) got_word = (got_word << NUM_SDI) | 32'(got[i]);
  endtask

  logic [31:0] exp_c;

  initial begin
    areset = 1'b1; spi_resetn = 1'b1; spi_csn = 1'b1; spi_sdi = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0; m_axis_tready = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("rst_status", status, 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd1);
    check("rst_sdo",    32'(spi_sdo), 32'd0);

    // Conversion frames: first returns 0, second returns the first pushed sample.
    push(32'h1234_5678);
    push(32'hCAFE_F00D);
    check("t1_level2", 32'(status[22:18]), 32'd2);
    frame(9, 24'd0, 0);
    check("t1_frame1_word", got_word, 32'd0);
    check("t1_uf_a", 32'(status[7:0]), 32'd0);
    check("t1_level1", 32'(status[22:18]), 32'd1);
    frame(9, 24'd0, 0);
    for (int i = 0; i < CHUNKS; i++) check("t1_chunk", 32'(got[i]), 32'(i + 1));
    check("t1_uf_b", 32'(status[7:0]), 32'd0);
    check("t1_level0", 32'(status[22:18]), 32'd0);

    // Register frame with ready high: one-cycle valid, sample retained.
    m_axis_tready = 1'b1;
    frame(25, 24'hA00123, 0);
    check("t2_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("t2_tdata", m_axis_tdata, 32'h00A0_0123);
    tick();
    check("t2_tvalid_clr", 32'(m_axis_tvalid), 32'd0);
    check("t2_cur_kept", 32'(spi_sdo), 32'hC);

    // Register frames with ready low: first held, second dropped.
    m_axis_tready = 1'b0;
    frame(25, 24'h111111, 0);
    frame(25, 24'h222222, 0);
    check("t3_sticky", 32'(status[16]), 32'd1);
    check("t3_tdata", m_axis_tdata, 32'h0011_1111);
    check("t3_tvalid", 32'(m_axis_tvalid), 32'd1);
    // Handshake coinciding with a new register frame end: new word taken.
    frame(25, 24'h333333, 1);
    check("t3_coinc_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("t3_coinc_tdata", m_axis_tdata, 32'h0033_3333);
    tick();
    check("t3_drain", 32'(m_axis_tvalid), 32'd0);

    // Underflow on an empty FIFO.
    frame(9, 24'd0, 0);
    check("t4_frame_a", got_word, 32'hCAFE_F00D);
    frame(9, 24'd0, 0);
    check("t4_frame_b", got_word, 32'd0);
    frame(9, 24'd0, 0);
`ifdef ADC_RESPONDER_RAMP_EN
    exp_c = 32'd1;
`else
    exp_c = 32'd0;
`endif
    check("t4_frame_c", got_word, exp_c);
    check("t4_uf", 32'(status[7:0]), 32'd3);

    // Short frame is a frame error.
    push(32'hDEAD_BEEF);
    frame(5, 24'd0, 0);
    check("t5_fe", 32'(status[15:8]), 32'd1);
    check("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t5_level", 32'(status[22:18]), 32'd1);

    // Reset in the middle of a conversion frame.
    spi_csn = 1'b0;
    repeat (4) tick();
    check("t6_active", 32'(status[17]), 32'd1);
    areset = 1'b1;
    tick();
    check("t6_status", status, 32'd0);
    check("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("t6_tdata", m_axis_tdata, 32'd0);
    check("t6_sdo", 32'(spi_sdo), 32'd0);
    check("t6_tready", 32'(s_axis_tready), 32'd1);
    areset = 1'b0;
    repeat (2) tick();
    check("t6_wait_high", 32'(status[17]), 32'd0);
    spi_csn = 1'b1;
    tick();
    frame(9, 24'd0, 0);
    check("t6_frame_word", got_word, 32'd0);
    check("t6_uf", 32'(status[7:0]), 32'd1);

    // spi_resetn low acts as reset.
    spi_resetn = 1'b0;
    tick();
    check("t7_status", status, 32'd0);
    spi_resetn = 1'b1;
    tick();

    // Fill the FIFO: ready drops at full, extra offer ignored, order preserved.
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i));
    check("t8_level_full", 32'(status[22:18]), 32'(DEPTH));
    check("t8_tready_full", 32'(s_axis_tready), 32'd0);
    push(32'hFFFF_FFFF);
    check("t8_level_hold", 32'(status[22:18]), 32'(DEPTH));
    frame(9, 24'd0, 0);
    frame(9, 24'd0, 0);
    check("t8_order", got_word, 32'h1000);
    check("t8_level_after", 32'(status[22:18]), 32'(DEPTH - 2));
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
